// File: rtl/frida_pkg.sv
// Shared FRIDA definitions: comparator mux defaults and scan FSM state type.
package frida_pkg;

    localparam int unsigned COMPMUX_N_CH_DEFAULT  = 16;
    localparam int unsigned COMPMUX_BLANK_DEFAULT = 2;

    // Auto-scan controller states
    typedef enum logic {
        IDLE,
        DWELL
    } scan_state_t;

endpackage

// File: rtl/compmux_scan_ctrl.sv
// Auto-scan controller: dwell counter, scan index and IDLE/DWELL FSM.
// While idle the scan index mirrors cur_sel, so enabling scan never causes a switch.
module compmux_scan_ctrl
    import frida_pkg::*;
#(
    parameter int unsigned N_CH    = COMPMUX_N_CH_DEFAULT,
    parameter int unsigned SEL_W   = $clog2(N_CH),
    parameter int unsigned DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               scan_en,
    input  logic [DWELL_W-1:0] scan_dwell,
    input  logic [SEL_W-1:0]   cur_sel,
    output logic [SEL_W-1:0]   scan_idx
);

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_CH - 1);

    scan_state_t        state;
    scan_state_t        state_nxt;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [DWELL_W-1:0] dwell_last;
    logic [SEL_W-1:0]   idx_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: scan_en level selects scanning
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (scan_en)  state_nxt = DWELL;
            DWELL:   if (!scan_en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Last count value of a dwell period; a dwell of 0 behaves as 1
    always_comb begin
        dwell_last = (scan_dwell == '0) ? '0 : scan_dwell - DWELL_W'(1);
    end

    // Dwell counter and scan index; idle keeps the index seeded from cur_sel
    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_cnt <= '0;
            idx_q     <= '0;
        end else if (state == IDLE) begin
            dwell_cnt <= '0;
            idx_q     <= cur_sel;
        end else if (scan_en) begin
            if (dwell_cnt == dwell_last) begin
                dwell_cnt <= '0;
                idx_q     <= (idx_q == LAST_IDX) ? '0 : idx_q + SEL_W'(1);
            end else begin
                dwell_cnt <= dwell_cnt + DWELL_W'(1);
            end
        end
    end

    // Output logic: scan index as seen by the target selector
    always_comb begin
        scan_idx = (state == DWELL) ? idx_q : cur_sel;
    end

endmodule

// File: rtl/compmux_seq.sv
// Clocked N_CH:1 comparator output mux with glitch-free blanking and auto-scan.
// Optional: COMPMUX_EDGECNT_EN adds edge_cnt; USE_POWER_PINS adds vdd_d/vss_d.
module compmux_seq
    import frida_pkg::*;
#(
    parameter int unsigned N_CH      = COMPMUX_N_CH_DEFAULT,
    parameter int unsigned SEL_W     = $clog2(N_CH),
    parameter int unsigned DWELL_W   = 16,
    parameter int unsigned BLANK_CYC = COMPMUX_BLANK_DEFAULT
) (
`ifdef USE_POWER_PINS
    inout  wire                vdd_d,
    inout  wire                vss_d,
`endif
    input  logic               clk,
    input  logic               rst,
    input  logic [N_CH-1:0]    adc_comp_out,
    input  logic [SEL_W-1:0]   mux_sel,
    input  logic               scan_en,
    input  logic [DWELL_W-1:0] scan_dwell,
    output logic               comp_out,
    output logic [SEL_W-1:0]   cur_sel,
    output logic               blanking,
    output logic               sel_err
`ifdef COMPMUX_EDGECNT_EN
    ,
    output logic [15:0]        edge_cnt
`endif
);

    localparam int unsigned       BCNT_W     = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;
    localparam logic [BCNT_W-1:0] BLANK_LOAD = BCNT_W'(BLANK_CYC);
    localparam logic [SEL_W:0]    N_CH_EXT   = (SEL_W + 1)'(N_CH);

    logic [SEL_W-1:0]  scan_idx;
    logic [SEL_W-1:0]  target;
    logic              sel_oob;
    logic              do_switch;
    logic              sample;
    logic [BCNT_W-1:0] blank_cnt;

    compmux_scan_ctrl #(
        .N_CH    (N_CH),
        .SEL_W   (SEL_W),
        .DWELL_W (DWELL_W)
    ) u_scan (
        .clk        (clk),
        .rst        (rst),
        .scan_en    (scan_en),
        .scan_dwell (scan_dwell),
        .cur_sel    (cur_sel),
        .scan_idx   (scan_idx)
    );

    // Target selection and switch detection; out-of-range static selects are ignored
    always_comb begin
        sel_oob   = ({1'b0, mux_sel} >= N_CH_EXT);
        target    = scan_en ? scan_idx : mux_sel;
        do_switch = (scan_en || !sel_oob) && (target != cur_sel);
        sample    = adc_comp_out[cur_sel];
    end

    // Channel register, blank counter and select-error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_sel   <= '0;
            blank_cnt <= '0;
            sel_err   <= 1'b0;
        end else begin
            sel_err <= !scan_en && sel_oob;
            if (do_switch) begin
                cur_sel   <= target;
                blank_cnt <= BLANK_LOAD;
            end else if (blank_cnt != '0) begin
                blank_cnt <= blank_cnt - BCNT_W'(1);
            end
        end
    end

    // Blanking flag is a decode of the registered counter
    always_comb begin
        blanking = (blank_cnt != '0);
    end

    // Registered output sample, forced low while blanking
    always_ff @(posedge clk) begin
        if (rst) begin
            comp_out <= 1'b0;
        end else begin
            comp_out <= blanking ? 1'b0 : sample;
        end
    end

`ifdef COMPMUX_EDGECNT_EN
    // Saturating count of 0->1 transitions of comp_out, cleared on every switch
    always_ff @(posedge clk) begin
        if (rst) begin
            edge_cnt <= '0;
        end else if (do_switch) begin
            edge_cnt <= '0;
        end else if (!blanking && sample && !comp_out && (edge_cnt != '1)) begin
            edge_cnt <= edge_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/compmux_seq.md
Name: compmux_seq

Overview:
Parametrised, clocked successor to the 16:1 comparator output mux for FRIDA. It selects one of N_CH ADC comparator outputs and drives the LVDS TX path. Channel changes are glitch-free: the output is blanked for a programmable number of cycles after every switch. An auto-scan mode rotates through channels with a fixed dwell time, so one pad can observe the whole array.

Parameters:
N_CH, 16, number of comparator inputs (2..64)
SEL_W, $clog2(N_CH), selection index width
DWELL_W, 16, width of scan dwell counter
BLANK_CYC, 2, output-blanking cycles after any channel change (0 = no blanking)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
adc_comp_out  input  N_CH  comparator outputs, channel i on bit i
mux_sel  input  SEL_W  static channel select (from SPI register)
scan_en  input  1  1 = auto-scan mode, 0 = static select
scan_dwell  input  DWELL_W  cycles per channel in scan mode; 0 treated as 1
comp_out  output  1  registered selected comparator output
cur_sel  output  SEL_W  channel currently routed to comp_out
blanking  output  1  high while the output is forced low after a switch
sel_err  output  1  high while mux_sel >= N_CH in static mode
vdd_d, vss_d  inout  1  digital supply, only under USE_POWER_PINS

Behaviour:
- Reset is synchronous, active-high, single clock.
- Reset values: comp_out=0, cur_sel=0, blanking=0, sel_err=0, dwell counter=0, blank counter=0.
- Target select:
  - Static mode: target = mux_sel.
  - Scan mode: target = internal scan index.
- Switch event: target != cur_sel at a rising edge. On that edge:
  - cur_sel <= target.
  - Blank counter loads BLANK_CYC; blanking=1 for exactly BLANK_CYC cycles; comp_out forced 0 meanwhile.
  - If BLANK_CYC=0, blanking never asserts.
- Datapath: comp_out <= adc_comp_out[cur_sel] when not blanking. Latency is 1 cycle from input to comp_out. The first unblanked sample of a new channel appears BLANK_CYC+1 cycles after the switch edge.
- Out-of-range select: mux_sel >= N_CH in static mode gives sel_err=1 (registered, 1-cycle latency). cur_sel holds its previous value and is not updated. comp_out continues from the held channel. N_CH=16 cannot produce this.
- Scan FSM, states IDLE / DWELL:
  - IDLE: entered when scan_en=0.
  - IDLE->DWELL on scan_en rising. Scan index starts at the current cur_sel, dwell counter=0.
  - DWELL: counter increments each cycle. When counter == max(scan_dwell,1)-1, the index advances, wrapping N_CH-1 -> 0, and the counter clears.
  - Blanking cycles count toward the dwell.
  - DWELL->IDLE on scan_en=0. The static target applies on the next edge, with a normal switch/blank.
- Simultaneous events:
  - A switch during active blanking reloads the blank counter to BLANK_CYC.
  - A scan_dwell change takes effect on the next comparison.
- Reset mid-scan or mid-blank returns all state to reset values on that edge.
- No combinational path from any input to comp_out.

Optional Feature:
COMPMUX_EDGECNT_EN
- With the macro: adds output edge_cnt [15:0], counting rising edges of the selected channel's registered sample while not blanking.
  - Saturates at 16'hFFFF.
  - Cleared to 0 on reset and on every switch event.
  - Lets the bench/DAQ estimate comparator toggle rate per channel.
- Without the macro: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package frida_pkg: COMPMUX_N_CH_DEFAULT=16, COMPMUX_BLANK_DEFAULT=2.
- Scan FSM state typedef (IDLE, DWELL) lives in the same package.
- One natural sub-module: compmux_scan_ctrl. It holds the dwell counter, scan index and FSM, and outputs the scan index. Datapath, blanking and error logic stay in the top.

Test Plan:
- Static select: reset, mux_sel=5, adc_comp_out=16'h0020, BLANK_CYC=2 -> cur_sel=5 one edge later; blanking high 2 cycles; comp_out=1 on the 4th edge after the mux_sel change; all outputs 0 during reset.
- Glitch-free switch: toggle all inputs every cycle, change mux_sel 3->12 -> comp_out=0 for exactly 2 cycles, then follows bit 12 with 1-cycle latency.
- Auto-scan wrap: scan_en=1, scan_dwell=4, start cur_sel=14 -> cur_sel sequence 14,15,0,1 each held 4 cycles; scan_dwell=0 advances every cycle.
- Reset mid-operation: assert rst during blanking at cur_sel=9 -> next edge cur_sel=0, blanking=0, comp_out=0; scan restarts at 0 after release if scan_en=1.
- Out-of-range: N_CH=12, mux_sel=13 -> sel_err=1 next edge, cur_sel unchanged; mux_sel=2 -> sel_err=0, normal switch.
- COMPMUX_EDGECNT_EN: 10 rising edges on the selected channel -> edge_cnt=10; switch channel -> edge_cnt=0; 70000 edges -> edge_cnt=16'hFFFF.
